// File: rtl/flit_dispatcher_pkg.sv
// flit_dispatcher_pkg: flit types, dup-table entry, FSM states and the ack-flit builder
package flit_dispatcher_pkg;
  localparam int NODE_W = 4;
  localparam int PKT_W = 8;
  localparam int FNUM_W = 4;
  localparam int PAYLOAD_W = 32;
  typedef logic [NODE_W-1:0] node_id_t;
  typedef struct packed {
    logic is_ack;
    node_id_t src_id;
    node_id_t dst_id;
    node_id_t prev_id;
    node_id_t next_id;
    logic [PKT_W-1:0] packet_id;
    logic [FNUM_W-1:0] flit_num;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;
  typedef struct packed {
    logic valid;
    node_id_t src_id;
    logic [PKT_W-1:0] packet_id;
    logic [FNUM_W-1:0] flit_num;
  } dup_entry_t;
  typedef enum logic {IDLE, DISPATCH} state_t;
  // hop-by-hop ack goes back to whoever sent us the flit (its prev_id)
  function automatic flit_t make_ack_flit(flit_t h, node_id_t id);
    make_ack_flit = '0;
    make_ack_flit.is_ack = 1'b1;
    make_ack_flit.src_id = id;
    make_ack_flit.prev_id = id;
    make_ack_flit.dst_id = h.prev_id;
    make_ack_flit.next_id = h.prev_id;
    make_ack_flit.packet_id = h.packet_id;
    make_ack_flit.flit_num = h.flit_num;
  endfunction
endpackage

// File: rtl/flit_dispatcher_dup_filter.sv
// flit_dispatcher_dup_filter: recent-flit table with combinational hit and FIFO replacement
// Ports: clk, rst; src_id/packet_id/flit_num key of the held flit; wr stores the key; hit flags a match.
module flit_dispatcher_dup_filter
  import flit_dispatcher_pkg::*;
#(
  parameter int DUP_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  node_id_t src_id,
  input  logic [PKT_W-1:0] packet_id,
  input  logic [FNUM_W-1:0] flit_num,
  input  logic wr,
  output logic hit
);
  localparam int PTR_W = $clog2(DUP_DEPTH);
  dup_entry_t tbl [DUP_DEPTH];
  logic [PTR_W-1:0] ptr;
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DUP_DEPTH; i++)
      hit = hit | (tbl[i].valid & tbl[i].src_id == src_id & tbl[i].packet_id == packet_id & tbl[i].flit_num == flit_num);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DUP_DEPTH; i++) tbl[i] <= '0;
      ptr <= '0;
    end else if (wr) begin
      tbl[ptr] <= '{valid: 1'b1, src_id: src_id, packet_id: packet_id, flit_num: flit_num};
      ptr <= ptr + 1'b1;
    end
  end
endmodule

// File: rtl/flit_dispatcher.sv
// flit_dispatcher: classifies received flits into ack-received, local delivery, forwarding or drop, and emits hop acks
// Ports: clk, rst, this_node_id; flit_in valid/ready; ack_flit, noc_to_cpu, forwarding valid/ready outputs;
//        ack_received pulse; saturating drop_count and dup_count.
module flit_dispatcher
  import flit_dispatcher_pkg::*;
#(
  parameter int DUP_DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  node_id_t this_node_id,
  input  flit_t flit_in,
  input  logic flit_in_valid,
  output logic flit_in_ready,
  output flit_t ack_flit,
  output logic ack_flit_valid,
  input  logic ack_flit_ready,
  output flit_t noc_to_cpu_flit,
  output logic noc_to_cpu_valid,
  input  logic noc_to_cpu_ready,
  output flit_t forwarding_flit,
  output logic forwarding_valid,
  input  logic forwarding_ready,
  output flit_t ack_received_flit,
  output logic ack_received_valid,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] dup_count
);
  state_t state, state_next;
  flit_t h, fwd;
  logic ack_done, deliver_done, hit;
  logic dispatching, for_me, rx_ack, data, dup, deliver_valid, to_cpu;
  logic ack_hs, deliver_hs, done, accept;
  flit_dispatcher_dup_filter #(.DUP_DEPTH(DUP_DEPTH)) u_dup (
    .clk(clk), .rst(rst), .src_id(h.src_id), .packet_id(h.packet_id),
    .flit_num(h.flit_num), .wr(deliver_hs), .hit(hit)
  );
  always_comb begin
    dispatching = state == DISPATCH;
    for_me = h.next_id == this_node_id;
    rx_ack = h.is_ack & for_me;
    data = !h.is_ack & for_me;
    to_cpu = h.dst_id == this_node_id;
    // once delivered, the table holds this flit; deliver_done keeps it from reading as a dup
    dup = data & hit & !deliver_done;
    deliver_valid = dispatching & data & !hit & !deliver_done;
    ack_flit_valid = dispatching & data & !ack_done;
    noc_to_cpu_valid = deliver_valid & to_cpu;
    forwarding_valid = deliver_valid & !to_cpu;
    ack_received_valid = dispatching & rx_ack;
    ack_hs = ack_flit_valid & ack_flit_ready;
    deliver_hs = (noc_to_cpu_valid & noc_to_cpu_ready) | (forwarding_valid & forwarding_ready);
    // non-data cases (ack received, drops) finish in their first dispatch cycle
    done = dispatching & (!data | ((ack_done | ack_hs) & (deliver_done | dup | deliver_hs)));
    flit_in_ready = !dispatching | done;
    accept = flit_in_valid & flit_in_ready;
    state_next = accept ? DISPATCH : done ? IDLE : state;
    fwd = h;
    fwd.prev_id = this_node_id;
    ack_flit = ack_flit_valid ? make_ack_flit(h, this_node_id) : '0;
    noc_to_cpu_flit = noc_to_cpu_valid ? h : '0;
    forwarding_flit = forwarding_valid ? fwd : '0;
    ack_received_flit = ack_received_valid ? h : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      ack_done <= 1'b0;
      deliver_done <= 1'b0;
      drop_count <= '0;
      dup_count <= '0;
    end else begin
      if (accept) begin
        h <= flit_in;
        ack_done <= 1'b0;
        deliver_done <= 1'b0;
      end else begin
        ack_done <= ack_done | ack_hs;
        deliver_done <= deliver_done | deliver_hs;
      end
      if (done & !for_me & drop_count != '1) drop_count <= drop_count + 1'b1;
      if (done & dup & dup_count != '1) dup_count <= dup_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_flit_dispatcher.sv
// tb_flit_dispatcher: scoreboard bench with directed flits for flit_dispatcher
module tb_flit_dispatcher;
  import flit_dispatcher_pkg::*;
  logic clk = 0, rst = 1;
  node_id_t this_node_id = 4'd3;
  flit_t flit_in = '0;
  logic flit_in_valid = 0, flit_in_ready;
  flit_t ack_flit, noc_to_cpu_flit, forwarding_flit, ack_received_flit;
  logic ack_flit_valid, noc_to_cpu_valid, forwarding_valid, ack_received_valid;
  logic ack_flit_ready = 1, noc_to_cpu_ready = 1, forwarding_ready = 1;
  logic [15:0] drop_count, dup_count;
  int tests = 0, fails = 0;
  flit_t exp_ack[$], exp_cpu[$], exp_fwd[$], exp_rcv[$];
  flit_dispatcher #(.DUP_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .this_node_id(this_node_id),
    .flit_in(flit_in), .flit_in_valid(flit_in_valid), .flit_in_ready(flit_in_ready),
    .ack_flit(ack_flit), .ack_flit_valid(ack_flit_valid), .ack_flit_ready(ack_flit_ready),
    .noc_to_cpu_flit(noc_to_cpu_flit), .noc_to_cpu_valid(noc_to_cpu_valid), .noc_to_cpu_ready(noc_to_cpu_ready),
    .forwarding_flit(forwarding_flit), .forwarding_valid(forwarding_valid), .forwarding_ready(forwarding_ready),
    .ack_received_flit(ack_received_flit), .ack_received_valid(ack_received_valid),
    .drop_count(drop_count), .dup_count(dup_count)
  );
  always #5 clk = ~clk;
  function automatic flit_t mk(logic a, node_id_t s, node_id_t d, node_id_t p, node_id_t n,
                               logic [7:0] pk, logic [3:0] fn, logic [31:0] pl);
    mk = '{is_ack: a, src_id: s, dst_id: d, prev_id: p, next_id: n, packet_id: pk, flit_num: fn, payload: pl};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic unexpected(input string name, input flit_t f);
    tests++;
    fails++;
    $display("FAIL %s: unexpected handshake got %h expected none", name, f);
  endtask
  always @(negedge clk) if (!rst) begin
    if (ack_flit_valid && ack_flit_ready) begin
      if (exp_ack.size() == 0) unexpected("ack_flit", ack_flit);
      else chk("ack_flit", 64'(ack_flit), 64'(exp_ack.pop_front()));
    end
    if (noc_to_cpu_valid && noc_to_cpu_ready) begin
      if (exp_cpu.size() == 0) unexpected("noc_to_cpu", noc_to_cpu_flit);
      else chk("noc_to_cpu", 64'(noc_to_cpu_flit), 64'(exp_cpu.pop_front()));
    end
    if (forwarding_valid && forwarding_ready) begin
      if (exp_fwd.size() == 0) unexpected("forwarding", forwarding_flit);
      else chk("forwarding", 64'(forwarding_flit), 64'(exp_fwd.pop_front()));
    end
    if (ack_received_valid) begin
      if (exp_rcv.size() == 0) unexpected("ack_received", ack_received_flit);
      else chk("ack_received", 64'(ack_received_flit), 64'(exp_rcv.pop_front()));
    end
  end
  task automatic send(input flit_t f);
    int n = 0;
    flit_in = f;
    flit_in_valid = 1;
    @(negedge clk);
    while (!flit_in_ready && n < 50) begin n++; @(negedge clk); end
    if (!flit_in_ready) chk("accept_timeout", 64'(flit_in_ready), 64'(1));
    @(posedge clk);
    #1 flit_in_valid = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!flit_in_ready && n < 50) begin n++; @(negedge clk); end
    if (!flit_in_ready) chk("idle_timeout", 64'(flit_in_ready), 64'(1));
    @(posedge clk);
    #1;
  endtask
  initial begin
    flit_t f, a;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_ready", 64'(flit_in_ready), 64'(1));
    chk("reset_valids", 64'({ack_flit_valid, noc_to_cpu_valid, forwarding_valid, ack_received_valid}), 64'(0));
    chk("reset_drop", 64'(drop_count), 64'(0));
    chk("reset_dup", 64'(dup_count), 64'(0));
    chk("reset_flits", 64'(ack_flit | noc_to_cpu_flit | forwarding_flit | ack_received_flit), 64'(0));
    @(posedge clk);
    #1;
    // local delivery plus ack, one cycle latency
    f = mk(0, 1, 3, 2, 3, 5, 0, 32'hAB);
    exp_cpu.push_back(f);
    exp_ack.push_back(mk(1, 3, 2, 3, 2, 5, 0, 0));
    send(f);
    @(negedge clk);
    chk("t1_both_valid", 64'({noc_to_cpu_valid, ack_flit_valid}), 64'(2'b11));
    wait_idle();
    chk("t1_ready_back", 64'(flit_in_ready), 64'(1));
    // forwarding stalled while ack completes
    exp_ack.push_back(mk(1, 3, 2, 3, 2, 6, 1, 0));
    exp_fwd.push_back(mk(0, 1, 7, 3, 3, 6, 1, 32'h1234));
    forwarding_ready = 0;
    send(mk(0, 1, 7, 2, 3, 6, 1, 32'h1234));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_fwd_valid", 64'(forwarding_valid), 64'(1));
      chk("t2_fwd_flit", 64'(forwarding_flit), 64'(mk(0, 1, 7, 3, 3, 6, 1, 32'h1234)));
      chk("t2_in_ready", 64'(flit_in_ready), 64'(0));
      chk("t2_ack_valid", 64'(ack_flit_valid), 64'(i == 0));
    end
    @(posedge clk);
    #1 forwarding_ready = 1;
    wait_idle();
    // same flit twice: second is ack only
    f = mk(0, 4, 3, 5, 3, 7, 2, 32'h77);
    a = mk(1, 3, 5, 3, 5, 7, 2, 0);
    exp_cpu.push_back(f);
    exp_ack.push_back(a);
    send(f);
    wait_idle();
    exp_ack.push_back(a);
    send(f);
    wait_idle();
    chk("t3_dup_count", 64'(dup_count), 64'(1));
    // received ack for us, then two drops
    exp_rcv.push_back(mk(1, 2, 3, 2, 3, 9, 0, 0));
    send(mk(1, 2, 3, 2, 3, 9, 0, 0));
    @(negedge clk);
    chk("t4_rcv_pulse", 64'(ack_received_valid), 64'(1));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t4_rcv_single", 64'(ack_received_valid), 64'(0));
    @(posedge clk);
    #1;
    send(mk(1, 2, 4, 2, 4, 9, 0, 0));
    wait_idle();
    send(mk(0, 1, 4, 2, 4, 8, 0, 5));
    wait_idle();
    chk("t4_drop_count", 64'(drop_count), 64'(2));
    chk("t4_dup_count", 64'(dup_count), 64'(1));
    // five distinct flits evict the first; resending it delivers again
    for (int k = 0; k < 5; k++) begin
      f = mk(0, 1, 3, 2, 3, 8'(20 + k), 0, 32'(k));
      exp_cpu.push_back(f);
      exp_ack.push_back(mk(1, 3, 2, 3, 2, 8'(20 + k), 0, 0));
      send(f);
      wait_idle();
    end
    f = mk(0, 1, 3, 2, 3, 20, 0, 0);
    exp_cpu.push_back(f);
    exp_ack.push_back(mk(1, 3, 2, 3, 2, 20, 0, 0));
    send(f);
    wait_idle();
    chk("t5_dup_count", 64'(dup_count), 64'(1));
    // reset while stalled on forwarding
    forwarding_ready = 0;
    exp_ack.push_back(mk(1, 3, 2, 3, 2, 30, 0, 0));
    send(mk(0, 1, 7, 2, 3, 30, 0, 0));
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("t6_valids", 64'({ack_flit_valid, noc_to_cpu_valid, forwarding_valid, ack_received_valid}), 64'(0));
    chk("t6_fwd_flit", 64'(forwarding_flit), 64'(0));
    chk("t6_ready", 64'(flit_in_ready), 64'(1));
    chk("t6_drop", 64'(drop_count), 64'(0));
    chk("t6_dup", 64'(dup_count), 64'(0));
    forwarding_ready = 1;
    repeat (3) @(posedge clk);
    chk("left_ack", 64'(exp_ack.size()), 64'(0));
    chk("left_cpu", 64'(exp_cpu.size()), 64'(0));
    chk("left_fwd", 64'(exp_fwd.size()), 64'(0));
    chk("left_rcv", 64'(exp_rcv.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
